weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_if.sv | 27 ++
 rtl/weight_loader.sv | 130 +++++++++++++
 tb/tb_weight_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// Handshake and array-facing signals of the weight loader, bundled for port connection.
// The master side drives ingress beats and shift permission, and the slave side is the loader itself.
interface weight_loader_if #(
  parameter int COLS = 4,
  parameter int WW   = 16
);
  // Ingress handshake: a beat transfers on a rising edge where w_valid && w_ready.
  // w_ready never depends on w_valid, and the source may drop w_valid at any time.
  logic                 w_valid;
  logic                 w_ready;
  logic [WW*COLS-1:0]   w_data;
  logic                 shift_en;
  logic [WW*COLS-1:0]   weight_out;
  logic                 load_weight;
  logic                 loaded;
  logic                 busy;

  modport master (
    output w_valid, w_data, shift_en,
    input  w_ready, weight_out, load_weight, loaded, busy
  );

  modport slave (
    input  w_valid, w_data, shift_en,
    output w_ready, weight_out, load_weight, loaded, busy
  );
endinterface

// File: rtl/weight_loader.sv
// Single-buffered weight tile loader: collects ROWS ingress rows, then shifts them into a
// systolic array's weight chain bottom row first, once the array grants shift_en.
module weight_loader #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int WW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  weight_loader_if.slave    bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  localparam int CW = $clog2(ROWS + 1);
  localparam int IW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(ROWS - 1);
  localparam logic [CW-1:0] SHIFT_END = CW'(ROWS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(ROWS - 1);

  state_t                state;
  state_t                state_nxt;
  // Beat index while filling, shift index k while shifting; ROWS in SHIFT marks the done cycle.
  logic [CW-1:0]         cnt;
  logic [WW*COLS-1:0]    wbuf [ROWS];

  logic                  accept;
  logic                  shift_step;
  logic                  shift_done;
  logic [IW-1:0]         fill_idx;
  logic [IW-1:0]         shift_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; shift_en only matters once the tile is complete.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (accept && (cnt == LAST_BEAT)) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.shift_en) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_done) begin
          state_nxt = S_FILL;
        end
      end
      default: begin
        state_nxt = S_FILL;
      end
    endcase
  end

  // Output / control decode from state and cnt only, so w_ready has no path from w_valid.
  always_comb begin
    bus.w_ready = (state == S_FILL);
    accept      = bus.w_valid && (state == S_FILL);
    shift_step  = (state == S_SHIFT) && (cnt != SHIFT_END);
    shift_done  = (state == S_SHIFT) && (cnt == SHIFT_END);
    bus.busy    = (state != S_FILL) || (cnt != '0);
    dbg_state   = state;
  end

  assign fill_idx  = cnt[IW-1:0];
  assign shift_idx = LAST_IDX - cnt[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
          end
        end
        S_FULL: begin
          cnt <= '0;
        end
        S_SHIFT: begin
          cnt <= shift_done ? '0 : cnt + CW'(1);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Tile storage is not reset; a reset simply abandons whatever it holds.
  always_ff @(posedge clk) begin
    if (accept) begin
      wbuf[fill_idx] <= bus.w_data;
    end
  end

  // Registered array-facing outputs; weight_out holds its last value between shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.load_weight <= 1'b0;
      bus.loaded      <= 1'b0;
      bus.weight_out  <= '0;
    end else begin
      bus.load_weight <= shift_step;
      bus.loaded      <= shift_done;
      if (shift_step) begin
        bus.weight_out <= wbuf[shift_idx];
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: randomized tiles checked against a row-list model of the tile
// and a behavioural PE weight-chain model.
module tb_weight_loader;

  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int WW   = 16;
  localparam int W    = WW * COLS;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  weight_loader_if #(.COLS(COLS), .WW(WW)) bus ();

  weight_loader #(.ROWS(ROWS), .COLS(COLS), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Rows accepted for the current tile, in acceptance order (row 0 = top PE).
  logic [W-1:0] exp_q[$];
  // PE chain model: pe[0] is the top PE, fed from weight_out on each load_weight cycle.
  logic [W-1:0] pe [ROWS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.load_weight) begin
      for (int r = ROWS - 1; r > 0; r--) pe[r] = pe[r-1];
      pe[0] = bus.weight_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.shift_en = 1'b0;
    repeat (3) step();
    chk("rst_load_weight", 64'(bus.load_weight), 64'd0);
    chk("rst_loaded", 64'(bus.loaded), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_weight_out", 64'(bus.weight_out), 64'd0);
    rst = 1'b0;
    chk("rst_w_ready", 64'(bus.w_ready), 64'd1);
  endtask

  // gap: 0 = w_valid held high, 1 = toggles 1,0,1,0, 2 = random.
  // abort_k >= 0 asserts rst during shift cycle abort_k instead of finishing the tile.
  task automatic run_tile(input int gap, input bit fixed, input int wait_cycles,
                          input bit early, input int abort_k);
    int cyc;
    bit v;
    logic [W-1:0] d;
    exp_q.delete();
    cyc = 0;
    // Fill: the loader must be ready in every cycle until ROWS beats are held.
    while (exp_q.size() < ROWS) begin
      case (gap)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      d = fixed ? {WW'(16'h0101 + exp_q.size()), WW'(16'h0001 + exp_q.size())}
                : W'($urandom);
      bus.w_valid  = v;
      bus.w_data   = d;
      bus.shift_en = early && (exp_q.size() == 2);
      chk("fill_w_ready", 64'(bus.w_ready), 64'd1);
      chk("fill_busy", 64'(bus.busy), 64'(exp_q.size() != 0));
      chk("fill_no_load", 64'(bus.load_weight), 64'd0);
      if (v) exp_q.push_back(d);
      step();
      cyc++;
    end
    bus.shift_en = 1'b0;
    // Backpressure: extra offered beats must be refused.
    for (int i = 0; i < 2; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = W'($urandom);
      chk("full_w_ready", 64'(bus.w_ready), 64'd0);
      chk("full_busy", 64'(bus.busy), 64'd1);
      chk("full_no_load", 64'(bus.load_weight), 64'd0);
      step();
    end
    for (int i = 0; i < wait_cycles; i++) begin
      bus.w_data = W'($urandom);
      chk("wait_w_ready", 64'(bus.w_ready), 64'd0);
      chk("wait_no_load", 64'(bus.load_weight), 64'd0);
      step();
    end
    // Edge t samples shift_en; shift cycles follow after edges t+1 .. t+ROWS.
    bus.shift_en = 1'b1;
    step();
    bus.shift_en = 1'b0;
    chk("shift_latency", 64'(bus.load_weight), 64'd0);
    for (int k = 0; k < ROWS; k++) begin
      step();
      chk("shift_load", 64'(bus.load_weight), 64'd1);
      chk("shift_data", 64'(bus.weight_out), 64'(exp_q[ROWS-1-k]));
      chk("shift_w_ready", 64'(bus.w_ready), 64'd0);
      chk("shift_no_loaded", 64'(bus.loaded), 64'd0);
      if (k == abort_k) begin
        rst = 1'b1;
        bus.w_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("abort_load", 64'(bus.load_weight), 64'd0);
        chk("abort_loaded", 64'(bus.loaded), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_w_ready", 64'(bus.w_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
          step();
          chk("abort_quiet_loaded", 64'(bus.loaded), 64'd0);
          chk("abort_quiet_load", 64'(bus.load_weight), 64'd0);
        end
        return;
      end
    end
    bus.w_valid = 1'b0;
    step();
    chk("done_load", 64'(bus.load_weight), 64'd0);
    chk("done_loaded", 64'(bus.loaded), 64'd1);
    chk("done_w_ready", 64'(bus.w_ready), 64'd1);
    chk("done_busy", 64'(bus.busy), 64'd0);
    step();
    chk("loaded_pulse_end", 64'(bus.loaded), 64'd0);
    chk("hold_weight_out", 64'(bus.weight_out), 64'(exp_q[0]));
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("pe_row%0d", r), 64'(pe[r]), 64'(exp_q[r]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int r = 0; r < ROWS; r++) pe[r] = '0;
    do_reset();
    // Known rows, continuous valid, short wait.
    run_tile(0, 1'b1, 0, 1'b0, -1);
    // Long delayed permission.
    run_tile(0, 1'b0, 10, 1'b0, -1);
    // shift_en during fill must not be remembered.
    run_tile(0, 1'b0, 4, 1'b1, -1);
    // Gapped ingress.
    run_tile(1, 1'b0, 2, 1'b0, -1);
    // Reset in the middle of the shift, then a clean reload.
    run_tile(0, 1'b0, 1, 1'b0, 2);
    run_tile(0, 1'b0, 0, 1'b0, -1);
    for (int t = 0; t < 6; t++) begin
      run_tile(int'($urandom_range(0, 2)), 1'b0, int'($urandom_range(1, 6)),
               1'($urandom_range(0, 1)), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
